// File: rtl/relobi_sbr_router.sv
// Single-subordinate to N-manager request router with in-order response return and a local abort target.
// Optional build macro RELOBI_SBR_ROUTER_ABORT_CNT_EN adds a saturating 16-bit abort handshake counter (abort_cnt_o).
module relobi_sbr_router #(
  parameter int unsigned          NumMgrPorts = 2,
  parameter int unsigned          NumMaxTrans = 4,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] ErrData     = 32'hBADCAB1E,
  parameter int unsigned          IdxWidth    = $clog2(NumMgrPorts)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [IdxWidth-1:0]              sel_i,
  input  logic                             sel_fault_i,
  input  logic                             sbr_req_i,
  output logic                             sbr_gnt_o,
  output logic                             sbr_rvalid_o,
  input  logic                             sbr_rready_i,
  output logic [DataWidth-1:0]             sbr_rdata_o,
  output logic                             sbr_err_o,
  output logic [NumMgrPorts-1:0]           mgr_req_o,
  input  logic [NumMgrPorts-1:0]           mgr_gnt_i,
  input  logic [NumMgrPorts-1:0]           mgr_rvalid_i,
  output logic [NumMgrPorts-1:0]           mgr_rready_o,
  input  logic [NumMgrPorts*DataWidth-1:0] mgr_rdata_i,
  input  logic [NumMgrPorts-1:0]           mgr_err_i,
  output logic                             busy_o
`ifdef RELOBI_SBR_ROUTER_ABORT_CNT_EN
  ,
  output logic [15:0]                      abort_cnt_o
`endif
);

  localparam int unsigned           CntWidth = $clog2(NumMaxTrans + 1);
  localparam logic [CntWidth-1:0]   CntMax   = CntWidth'(NumMaxTrans);
  localparam logic [IdxWidth:0]     NumPorts = (IdxWidth + 1)'(NumMgrPorts);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0] cur_idx_q, cur_idx_d;
  logic                cur_abort_q, cur_abort_d;

  logic t_abort;
  logic same_tgt;
  logic blocked;
  logic a_hs;
  logic r_hs;

  // Request side: the abort target is a separate flag so that any sel_i value can be aborted.
  always_comb begin
    t_abort   = sel_fault_i || ({1'b0, sel_i} >= NumPorts);
    same_tgt  = cur_abort_q ? t_abort : (!t_abort && (sel_i == cur_idx_q));
    blocked   = (cnt_q == CntMax) || ((cnt_q != '0) && !same_tgt);
    mgr_req_o = '0;
    sbr_gnt_o = 1'b0;
    if (!rst_i && !blocked) begin
      if (t_abort) begin
        sbr_gnt_o = sbr_req_i;
      end else begin
        for (int unsigned p = 0; p < NumMgrPorts; p++) begin
          if (IdxWidth'(p) == sel_i) begin
            mgr_req_o[p] = sbr_req_i;
            sbr_gnt_o    = mgr_gnt_i[p];
          end
        end
      end
    end
  end

  // Response side is gated by cnt so stray rvalid with nothing outstanding cannot underflow it.
  always_comb begin
    sbr_rvalid_o = 1'b0;
    sbr_rdata_o  = '0;
    sbr_err_o    = 1'b0;
    mgr_rready_o = '0;
    if (!rst_i && (cnt_q != '0)) begin
      if (cur_abort_q) begin
        sbr_rvalid_o = 1'b1;
        sbr_rdata_o  = ErrData;
        sbr_err_o    = 1'b1;
      end else begin
        for (int unsigned p = 0; p < NumMgrPorts; p++) begin
          if (IdxWidth'(p) == cur_idx_q) begin
            sbr_rvalid_o    = mgr_rvalid_i[p];
            sbr_rdata_o     = mgr_rdata_i[p*DataWidth +: DataWidth];
            sbr_err_o       = mgr_err_i[p];
            mgr_rready_o[p] = sbr_rready_i;
          end
        end
      end
    end
  end

  always_comb begin
    a_hs        = sbr_req_i && sbr_gnt_o;
    r_hs        = sbr_rvalid_o && sbr_rready_i;
    cnt_d       = cnt_q;
    cur_idx_d   = cur_idx_q;
    cur_abort_d = cur_abort_q;
    if (a_hs && !r_hs) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!a_hs && r_hs) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (a_hs) begin
      cur_idx_d   = sel_i;
      cur_abort_d = t_abort;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      cur_idx_q   <= '0;
      cur_abort_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_idx_q   <= cur_idx_d;
      cur_abort_q <= cur_abort_d;
    end
  end

  assign busy_o = !rst_i && (cnt_q != '0);

`ifdef RELOBI_SBR_ROUTER_ABORT_CNT_EN
  logic [15:0] abort_cnt_q, abort_cnt_d;

  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (a_hs && t_abort && (abort_cnt_q != 16'hFFFF)) begin
      abort_cnt_d = abort_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      abort_cnt_q <= '0;
    end else begin
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt_o = rst_i ? 16'h0000 : abort_cnt_q;
`else
  // Abort counting is not built in this configuration.
`endif

endmodule

// File: tb/tb_relobi_sbr_router.sv
// Self-checking bench for relobi_sbr_router: directed scenarios plus randomized traffic against a queue model.
module tb_relobi_sbr_router;
  localparam int NP = 3;
  localparam int NT = 4;
  localparam int DW = 32;
  localparam logic [31:0] ERR = 32'hBADCAB1E;

  logic            clk;
  logic            rst_i;
  logic [1:0]      sel_i;
  logic            sel_fault_i;
  logic            sbr_req_i;
  logic            sbr_gnt_o;
  logic            sbr_rvalid_o;
  logic            sbr_rready_i;
  logic [DW-1:0]   sbr_rdata_o;
  logic            sbr_err_o;
  logic [NP-1:0]   mgr_req_o;
  logic [NP-1:0]   mgr_gnt_i;
  logic [NP-1:0]   mgr_rvalid_i;
  logic [NP-1:0]   mgr_rready_o;
  logic [NP*DW-1:0] mgr_rdata_i;
  logic [NP-1:0]   mgr_err_i;
  logic            busy_o;
`ifdef RELOBI_SBR_ROUTER_ABORT_CNT_EN
  logic [15:0]     abort_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  relobi_sbr_router #(
    .NumMgrPorts(NP),
    .NumMaxTrans(NT),
    .DataWidth  (DW),
    .ErrData    (ERR)
  ) dut (
`ifdef RELOBI_SBR_ROUTER_ABORT_CNT_EN
    .abort_cnt_o (abort_cnt_o),
`endif
    .clk_i       (clk),
    .rst_i       (rst_i),
    .sel_i       (sel_i),
    .sel_fault_i (sel_fault_i),
    .sbr_req_i   (sbr_req_i),
    .sbr_gnt_o   (sbr_gnt_o),
    .sbr_rvalid_o(sbr_rvalid_o),
    .sbr_rready_i(sbr_rready_i),
    .sbr_rdata_o (sbr_rdata_o),
    .sbr_err_o   (sbr_err_o),
    .mgr_req_o   (mgr_req_o),
    .mgr_gnt_i   (mgr_gnt_i),
    .mgr_rvalid_i(mgr_rvalid_i),
    .mgr_rready_o(mgr_rready_o),
    .mgr_rdata_i (mgr_rdata_i),
    .mgr_err_i   (mgr_err_i),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    sel_i        = '0;
    sel_fault_i  = 1'b0;
    sbr_req_i    = 1'b0;
    sbr_rready_i = 1'b0;
    mgr_gnt_i    = '0;
    mgr_rvalid_i = '0;
    mgr_rdata_i  = '0;
    mgr_err_i    = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1;
    sbr_req_i = 1'b1; sel_i = 2'd0; mgr_gnt_i = '1; mgr_rvalid_i = '1; sbr_rready_i = 1'b1;
    #1;
    checks++; if ({sbr_gnt_o, sbr_rvalid_o, sbr_err_o, mgr_req_o, mgr_rready_o, busy_o} !== 10'h0) begin
      errors++; $display("FAIL reset_outputs got=%b want=0", {sbr_gnt_o, sbr_rvalid_o, sbr_err_o, mgr_req_o, mgr_rready_o, busy_o}); end
`ifdef RELOBI_SBR_ROUTER_ABORT_CNT_EN
    checks++; if (abort_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_abort_cnt got=%h want=0", abort_cnt_o); end
`endif
    @(negedge clk);
    idle(); rst_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (sbr_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b want=0", sbr_rvalid_o); end
  endtask

  task automatic test_basic();
    do_reset();
    sbr_req_i = 1'b1; sel_i = 2'd1; mgr_gnt_i = 3'b010;
    #1;
    checks++; if (sbr_gnt_o !== 1'b1) begin errors++; $display("FAIL basic_gnt got=%b want=1", sbr_gnt_o); end
    checks++; if (mgr_req_o !== 3'b010) begin errors++; $display("FAIL basic_mgr_req got=%b want=010", mgr_req_o); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", busy_o); end
    checks++; if (sbr_rvalid_o !== 1'b0) begin errors++; $display("FAIL basic_early_rvalid got=%b want=0", sbr_rvalid_o); end
    @(negedge clk);
    mgr_rvalid_i = 3'b010; mgr_rdata_i[DW +: DW] = 32'h12345678; sbr_rready_i = 1'b1;
    #1;
    checks++; if (sbr_rvalid_o !== 1'b1) begin errors++; $display("FAIL basic_rvalid got=%b want=1", sbr_rvalid_o); end
    checks++; if (sbr_rdata_o !== 32'h12345678) begin errors++; $display("FAIL basic_rdata got=%h want=12345678", sbr_rdata_o); end
    checks++; if (sbr_err_o !== 1'b0) begin errors++; $display("FAIL basic_err got=%b want=0", sbr_err_o); end
    checks++; if (mgr_rready_o !== 3'b010) begin errors++; $display("FAIL basic_rready got=%b want=010", mgr_rready_o); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_done_busy got=%b want=0", busy_o); end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    for (int i = 0; i < NT; i++) begin
      sbr_req_i = 1'b1; sel_i = 2'd0; mgr_gnt_i = 3'b001;
      #1;
      checks++; if (sbr_gnt_o !== 1'b1) begin errors++; $display("FAIL max_fill_gnt%0d got=%b want=1", i, sbr_gnt_o); end
      @(negedge clk);
    end
    #1;
    checks++; if (sbr_gnt_o !== 1'b0) begin errors++; $display("FAIL max_block_gnt got=%b want=0", sbr_gnt_o); end
    checks++; if (mgr_req_o !== 3'b000) begin errors++; $display("FAIL max_block_req got=%b want=000", mgr_req_o); end
    mgr_rvalid_i = 3'b001; sbr_rready_i = 1'b1;
    #1;
    checks++; if (sbr_gnt_o !== 1'b0) begin errors++; $display("FAIL max_block_during_r got=%b want=0", sbr_gnt_o); end
    @(negedge clk);
    mgr_rvalid_i = 3'b000;
    #1;
    checks++; if (sbr_gnt_o !== 1'b1) begin errors++; $display("FAIL max_unblock_gnt got=%b want=1", sbr_gnt_o); end
    @(negedge clk);
    sbr_req_i = 1'b0;
    for (int i = 0; i < NT; i++) begin
      mgr_rvalid_i = 3'b001; sbr_rready_i = 1'b1;
      @(negedge clk);
    end
    idle();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL max_drain_busy got=%b want=0", busy_o); end
  endtask

  task automatic test_switch_target();
    do_reset();
    sbr_req_i = 1'b1; sel_i = 2'd0; mgr_gnt_i = 3'b001;
    @(negedge clk);
    sel_i = 2'd1; mgr_gnt_i = 3'b010;
    #1;
    checks++; if (sbr_gnt_o !== 1'b0) begin errors++; $display("FAIL switch_block_gnt got=%b want=0", sbr_gnt_o); end
    checks++; if (mgr_req_o !== 3'b000) begin errors++; $display("FAIL switch_block_req got=%b want=000", mgr_req_o); end
    mgr_rvalid_i = 3'b001; sbr_rready_i = 1'b1;
    #1;
    checks++; if (sbr_gnt_o !== 1'b0) begin errors++; $display("FAIL switch_block_r got=%b want=0", sbr_gnt_o); end
    @(negedge clk);
    mgr_rvalid_i = 3'b000;
    #1;
    checks++; if (sbr_gnt_o !== 1'b1) begin errors++; $display("FAIL switch_gnt got=%b want=1", sbr_gnt_o); end
    checks++; if (mgr_req_o !== 3'b010) begin errors++; $display("FAIL switch_req got=%b want=010", mgr_req_o); end
    @(negedge clk);
    sbr_req_i = 1'b0; mgr_rvalid_i = 3'b010; mgr_rdata_i[DW +: DW] = 32'hCAFE0001;
    #1;
    checks++; if (sbr_rdata_o !== 32'hCAFE0001) begin errors++; $display("FAIL switch_rdata got=%h want=cafe0001", sbr_rdata_o); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL switch_busy got=%b want=0", busy_o); end
  endtask

  task automatic test_abort();
    do_reset();
    sel_fault_i = 1'b1; sbr_req_i = 1'b1; sbr_rready_i = 1'b1; sel_i = 2'd0; mgr_gnt_i = 3'b000;
    #1;
    checks++; if (sbr_gnt_o !== 1'b1) begin errors++; $display("FAIL abort_gnt got=%b want=1", sbr_gnt_o); end
    checks++; if (mgr_req_o !== 3'b000) begin errors++; $display("FAIL abort_req got=%b want=000", mgr_req_o); end
    checks++; if (sbr_rvalid_o !== 1'b0) begin errors++; $display("FAIL abort_rvalid_early got=%b want=0", sbr_rvalid_o); end
    @(negedge clk);
    sbr_req_i = 1'b0; sel_fault_i = 1'b0;
    #1;
    checks++; if (sbr_rvalid_o !== 1'b1) begin errors++; $display("FAIL abort_rvalid got=%b want=1", sbr_rvalid_o); end
    checks++; if (sbr_rdata_o !== ERR) begin errors++; $display("FAIL abort_rdata got=%h want=%h", sbr_rdata_o, ERR); end
    checks++; if (sbr_err_o !== 1'b1) begin errors++; $display("FAIL abort_err got=%b want=1", sbr_err_o); end
    checks++; if (mgr_rready_o !== 3'b000) begin errors++; $display("FAIL abort_rready got=%b want=000", mgr_rready_o); end
`ifdef RELOBI_SBR_ROUTER_ABORT_CNT_EN
    checks++; if (abort_cnt_o !== 16'd1) begin errors++; $display("FAIL abort_cnt got=%0d want=1", abort_cnt_o); end
`endif
    @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy_o); end
    sel_i = 2'd3; sbr_req_i = 1'b1;
    #1;
    checks++; if ({sbr_gnt_o, mgr_req_o} !== 4'b1000) begin errors++; $display("FAIL abort_range got=%b want=1000", {sbr_gnt_o, mgr_req_o}); end
    @(negedge clk);
    sbr_req_i = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sbr_req_i = 1'b1; sel_i = 2'd0; mgr_gnt_i = 3'b001;
      @(negedge clk);
    end
    idle();
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b want=1", busy_o); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++; if ({sbr_gnt_o, sbr_rvalid_o, sbr_err_o, mgr_req_o, mgr_rready_o, busy_o} !== 10'h0) begin
      errors++; $display("FAIL mid_outputs got=%b want=0", {sbr_gnt_o, sbr_rvalid_o, sbr_err_o, mgr_req_o, mgr_rready_o, busy_o}); end
    mgr_rvalid_i = 3'b001; sbr_rready_i = 1'b1;
    #1;
    checks++; if ({sbr_rvalid_o, mgr_rready_o} !== 4'b0000) begin errors++; $display("FAIL mid_ignore got=%b want=0000", {sbr_rvalid_o, mgr_rready_o}); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy_after got=%b want=0", busy_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    sbr_req_i = 1'b1; sel_i = 2'd0; mgr_gnt_i = 3'b001;
    @(negedge clk);
    mgr_rvalid_i = 3'b001; sbr_rready_i = 1'b1;
    #1;
    checks++; if ({sbr_gnt_o, sbr_rvalid_o} !== 2'b11) begin errors++; $display("FAIL simul_hs got=%b want=11", {sbr_gnt_o, sbr_rvalid_o}); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL simul_busy got=%b want=1", busy_o); end
    mgr_rvalid_i = 3'b001; sbr_rready_i = 1'b1;
    #1;
    checks++; if (sbr_rvalid_o !== 1'b1) begin errors++; $display("FAIL simul_rvalid got=%b want=1", sbr_rvalid_o); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL simul_empty got=%b want=0", busy_o); end
  endtask

  // Model: a FIFO of targets for granted-but-unanswered transactions (-1 marks the abort target).
  task automatic test_random(input int n);
    int q[$];
    int tgt, head, ab_exp;
    logic blk, e_gnt, e_rv, e_err, a_hs, r_hs;
    logic [NP-1:0] e_req, e_rr;
    logic [DW-1:0] e_rd;
    ab_exp = 0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      head         = (q.size() != 0) ? q[0] : -2;
      sbr_req_i    = ($urandom % 3) != 0;
      sel_i        = 2'($urandom % 4);
      sel_fault_i  = ($urandom % 8) == 0;
      mgr_gnt_i    = NP'($urandom);
      mgr_err_i    = NP'($urandom);
      sbr_rready_i = ($urandom % 4) != 0;
      for (int p = 0; p < NP; p++) begin
        mgr_rdata_i[p*DW +: DW] = $urandom;
        mgr_rvalid_i[p] = (p == head) ? 1'($urandom % 2) : (($urandom % 4) == 0);
      end
      #1;
      tgt   = (sel_fault_i || (int'(sel_i) >= NP)) ? -1 : int'(sel_i);
      blk   = (q.size() == NT) || ((q.size() != 0) && (q[0] != tgt));
      e_gnt = blk ? 1'b0 : ((tgt < 0) ? sbr_req_i : mgr_gnt_i[tgt]);
      e_req = (!blk && (tgt >= 0) && sbr_req_i) ? (NP'(1) << tgt) : '0;
      e_rv = 1'b0; e_rd = '0; e_err = 1'b0; e_rr = '0;
      if (head == -1) begin
        e_rv = 1'b1; e_rd = ERR; e_err = 1'b1;
      end else if (head >= 0) begin
        e_rv = mgr_rvalid_i[head]; e_rd = mgr_rdata_i[head*DW +: DW]; e_err = mgr_err_i[head];
        e_rr = NP'(sbr_rready_i) << head;
      end
      checks++; if (sbr_gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", c, sbr_gnt_o, e_gnt); end
      checks++; if (mgr_req_o !== e_req) begin errors++; $display("FAIL rnd_mgr_req cyc=%0d got=%b want=%b", c, mgr_req_o, e_req); end
      checks++; if (sbr_rvalid_o !== e_rv) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b want=%b", c, sbr_rvalid_o, e_rv); end
      checks++; if (mgr_rready_o !== e_rr) begin errors++; $display("FAIL rnd_rready cyc=%0d got=%b want=%b", c, mgr_rready_o, e_rr); end
      checks++; if (busy_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", c, busy_o, q.size() != 0); end
      if (e_rv) begin
        checks++; if ({sbr_err_o, sbr_rdata_o} !== {e_err, e_rd}) begin
          errors++; $display("FAIL rnd_rpayload cyc=%0d got=%b/%h want=%b/%h", c, sbr_err_o, sbr_rdata_o, e_err, e_rd); end
      end
`ifdef RELOBI_SBR_ROUTER_ABORT_CNT_EN
      checks++; if (abort_cnt_o !== 16'(ab_exp)) begin errors++; $display("FAIL rnd_abort_cnt cyc=%0d got=%0d want=%0d", c, abort_cnt_o, ab_exp); end
`endif
      a_hs = sbr_req_i && e_gnt;
      r_hs = e_rv && sbr_rready_i;
      if (r_hs) void'(q.pop_front());
      if (a_hs) begin
        q.push_back(tgt);
        if (tgt < 0) ab_exp++;
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_max_outstanding();
    test_switch_target();
    test_abort();
    test_reset_midflight();
    test_simultaneous();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
